mul: RTL and testbench

MUL -- requirements
Module: mul

---
 rtl/mul.sv | 114 +++++++++++
 tb/tb_mul.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/mul.sv
// Two-stage pipelined BFloat16 multiplier: stage 1 registers the operands,
// stage 2 computes the product, handles the special cases and registers every output.
module mul (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [15:0] flp_a,
  input  logic [15:0] flp_b,
  output logic        out_valid,
  output logic [8:0]  exponent,
  output logic [8:0]  exp_unbiased,
  output logic [9:0]  exp_sum,
  output logic [6:0]  prod,
  output logic [15:0] sum
);

  // Stage 1: operand capture
  logic [15:0] a_reg, b_reg;
  logic        v1_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      a_reg  <= '0;
      b_reg  <= '0;
      v1_reg <= 1'b0;
    end else begin
      v1_reg <= in_valid;
      if (in_valid) begin
        a_reg <= flp_a;
        b_reg <= flp_b;
      end
    end
  end

  // Stage 2 datapath
  logic        sign_next;
  logic [7:0]  ea, eb;
  logic [15:0] p_full;
  logic        norm;
  logic [8:0]  exponent_next;
  logic [8:0]  exp_unbiased_next;
  logic [9:0]  exp_sum_next;
  logic [6:0]  prod_next;
  logic [15:0] sum_next;
  logic        a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;

  assign ea        = a_reg[14:7];
  assign eb        = b_reg[14:7];
  assign sign_next = a_reg[15] ^ b_reg[15];
  assign p_full    = {8'd0, 1'b1, a_reg[6:0]} * {8'd0, 1'b1, b_reg[6:0]};
  assign norm      = p_full[15];
  assign prod_next = norm ? p_full[14:8] : p_full[13:7];

  assign exponent_next     = {1'b0, ea} + {1'b0, eb};
  assign exp_unbiased_next = exponent_next - 9'd127;
  assign exp_sum_next      = {1'b0, exponent_next} - 10'd127 + {9'd0, norm};

  assign a_zero = (ea == 8'd0);
  assign b_zero = (eb == 8'd0);
  assign a_nan  = (ea == 8'hFF) && (a_reg[6:0] != 7'd0);
  assign b_nan  = (eb == 8'hFF) && (b_reg[6:0] != 7'd0);
  assign a_inf  = (ea == 8'hFF) && (a_reg[6:0] == 7'd0);
  assign b_inf  = (eb == 8'hFF) && (b_reg[6:0] == 7'd0);

  // Special cases in priority order: NaN, Inf, zero input, overflow, underflow.
  always_comb begin
    sum_next = {sign_next, exp_sum_next[7:0], prod_next};
    if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero))
      sum_next = 16'h7FC0;
    else if (a_inf || b_inf)
      sum_next = {sign_next, 8'hFF, 7'd0};
    else if (a_zero || b_zero)
      sum_next = {sign_next, 15'd0};
    else if ($signed(exp_sum_next) >= 10'sd255)
      sum_next = {sign_next, 8'hFF, 7'd0};
    else if ($signed(exp_sum_next) <= 10'sd0)
      sum_next = {sign_next, 15'd0};
  end

  // Stage 2: output registers hold their value between valid results
  logic        out_valid_reg;
  logic [8:0]  exponent_reg, exp_unbiased_reg;
  logic [9:0]  exp_sum_reg;
  logic [6:0]  prod_reg;
  logic [15:0] sum_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_reg    <= 1'b0;
      exponent_reg     <= '0;
      exp_unbiased_reg <= '0;
      exp_sum_reg      <= '0;
      prod_reg         <= '0;
      sum_reg          <= '0;
    end else begin
      out_valid_reg <= v1_reg;
      if (v1_reg) begin
        exponent_reg     <= exponent_next;
        exp_unbiased_reg <= exp_unbiased_next;
        exp_sum_reg      <= exp_sum_next;
        prod_reg         <= prod_next;
        sum_reg          <= sum_next;
      end
    end
  end

  assign out_valid    = out_valid_reg;
  assign exponent     = exponent_reg;
  assign exp_unbiased = exp_unbiased_reg;
  assign exp_sum      = exp_sum_reg;
  assign prod         = prod_reg;
  assign sum          = sum_reg;

endmodule

// File: tb/tb_mul.sv
// Randomized and directed bench for the BFloat16 multiplier, checked against a
// value-level reference model with a 2-cycle delay line.
module tb_mul;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic [15:0] flp_a = '0, flp_b = '0;
  logic        out_valid;
  logic [8:0]  exponent, exp_unbiased;
  logic [9:0]  exp_sum;
  logic [6:0]  prod;
  logic [15:0] sum;

  mul dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .flp_a(flp_a), .flp_b(flp_b),
    .out_valid(out_valid), .exponent(exponent), .exp_unbiased(exp_unbiased),
    .exp_sum(exp_sum), .prod(prod), .sum(sum)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        valid;
    logic [8:0]  exponent;
    logic [8:0]  exp_unbiased;
    logic [9:0]  exp_sum;
    logic [6:0]  prod;
    logic [15:0] sum;
  } res_t;

  int tests_run = 0;
  int tests_failed = 0;
  int pulses = 0;

  res_t        exp_out = '0;
  logic        pend_valid = 1'b0;
  logic [15:0] pend_a = '0, pend_b = '0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    tests_run++;
    if (got !== want) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h", tag, got, want);
    end
  endtask

  // Reference: plain integer arithmetic on real-number semantics of BFloat16
  function automatic res_t model(input logic [15:0] a, input logic [15:0] b);
    res_t r;
    int ea, eb, ma, mb, p, nrm, es, pr;
    logic s;
    bit za, zb, ia, ib, na, nb;
    ea = int'(a[14:7]); eb = int'(b[14:7]);
    ma = 128 + int'(a[6:0]); mb = 128 + int'(b[6:0]);
    p = ma * mb;
    nrm = (p >= 32768) ? 1 : 0;
    pr = nrm ? (p / 256) % 128 : (p / 128) % 128;
    es = ea + eb - 127 + nrm;
    s = a[15] ^ b[15];
    za = (ea == 0); zb = (eb == 0);
    na = (ea == 255) && (a[6:0] != 0); nb = (eb == 255) && (b[6:0] != 0);
    ia = (ea == 255) && (a[6:0] == 0); ib = (eb == 255) && (b[6:0] == 0);
    r.valid        = 1'b1;
    r.exponent     = 9'(ea + eb);
    r.exp_unbiased = 9'(ea + eb - 127);
    r.exp_sum      = 10'(es);
    r.prod         = 7'(pr);
    if (na || nb || (ia && zb) || (ib && za)) r.sum = 16'h7FC0;
    else if (ia || ib)                        r.sum = {s, 8'hFF, 7'd0};
    else if (za || zb)                        r.sum = {s, 15'd0};
    else if (es >= 255)                       r.sum = {s, 8'hFF, 7'd0};
    else if (es <= 0)                         r.sum = {s, 15'd0};
    else                                      r.sum = {s, 8'(es), 7'(pr)};
    return r;
  endfunction

  // One clock: drive, advance the model at the edge, then compare everything.
  task automatic step(input logic [15:0] a, input logic [15:0] b, input logic v, input logic r);
    @(negedge clk);
    flp_a = a; flp_b = b; in_valid = v; rst = r;
    @(posedge clk);
    if (r) begin
      exp_out = '0;
    end else if (pend_valid) begin
      exp_out = model(pend_a, pend_b);
    end else begin
      exp_out.valid = 1'b0;
    end
    pend_valid = v && !r;
    pend_a = a; pend_b = b;
    #1;
    if (out_valid === 1'b1) pulses++;
    check("out_valid", 32'(out_valid), 32'(exp_out.valid));
    check("exponent", 32'(exponent), 32'(exp_out.exponent));
    check("exp_unbiased", 32'(exp_unbiased), 32'(exp_out.exp_unbiased));
    check("exp_sum", 32'(exp_sum), 32'(exp_out.exp_sum));
    check("prod", 32'(prod), 32'(exp_out.prod));
    check("sum", 32'(sum), 32'(exp_out.sum));
  endtask

  // Feed one pair, wait for it, and also check sum against a literal.
  task automatic vec(input logic [15:0] a, input logic [15:0] b, input logic [15:0] want);
    step(a, b, 1'b1, 1'b0);
    step(16'h0, 16'h0, 1'b0, 1'b0);
    check("vec_sum", 32'(sum), 32'(want));
    check("vec_valid", 32'(out_valid), 32'd1);
  endtask

  function automatic logic [15:0] gen_operand();
    logic [15:0] x;
    int cat;
    x = 16'($urandom);
    cat = int'($urandom_range(0, 9));
    case (cat)
      0: x[14:7] = 8'h00;
      1: begin x[14:7] = 8'hFF; x[6:0] = 7'd0; end
      2: begin x[14:7] = 8'hFF; x[6:0] = 7'($urandom_range(1, 127)); end
      3: x[14:7] = 8'($urandom_range(190, 254));
      4: x[14:7] = 8'($urandom_range(1, 70));
      default: x[14:7] = 8'($urandom_range(1, 254));
    endcase
    return x;
  endfunction

  initial begin
    // Reset with garbage valid inputs: nothing may emerge
    step(16'hAAAA, 16'hCCCC, 1'b1, 1'b1);
    step(16'h3F80, 16'h4000, 1'b1, 1'b1);
    check("rst_sum", 32'(sum), 32'd0);
    check("rst_valid", 32'(out_valid), 32'd0);
    step(16'h0, 16'h0, 1'b0, 1'b0);
    check("post_rst_valid", 32'(out_valid), 32'd0);

    step(16'hAAAA, 16'hCCCC, 1'b1, 1'b0);
    step(16'h0, 16'h0, 1'b0, 1'b0);
    check("ex_exponent", 32'(exponent), 32'h0EE);
    check("ex_exp_unb", 32'(exp_unbiased), 32'h06F);
    check("ex_exp_sum", 32'(exp_sum), 32'h070);
    check("ex_prod", 32'(prod), 32'h07);
    check("ex_sum", 32'(sum), 32'h3807);
    step(16'h0, 16'h0, 1'b0, 1'b0);
    check("hold_sum", 32'(sum), 32'h3807);

    vec(16'h3F80, 16'h4000, 16'h4000);
    check("one_two_exp", 32'(exp_sum), 32'd128);
    vec(16'hBF80, 16'h4000, 16'hC000);
    vec(16'h7F80, 16'h0000, 16'h7FC0);
    vec(16'h7F80, 16'hBF80, 16'hFF80);
    vec(16'h7F00, 16'h7F00, 16'h7F80);
    vec(16'h0080, 16'h0080, 16'h0000);
    vec(16'h7FC1, 16'h7F80, 16'h7FC0);
    vec(16'h8000, 16'h4000, 16'h8000);

    // Back-to-back three results
    pulses = 0;
    step(16'h3F80, 16'h3F80, 1'b1, 1'b0);
    step(16'h4000, 16'h4040, 1'b1, 1'b0);
    step(16'hC0A0, 16'h3FC0, 1'b1, 1'b0);
    step(16'h0, 16'h0, 1'b0, 1'b0);
    step(16'h0, 16'h0, 1'b0, 1'b0);
    step(16'h0, 16'h0, 1'b0, 1'b0);
    check("b2b_pulses", 32'(pulses), 32'd3);

    // Reset mid-stream flushes in-flight work
    pulses = 0;
    step(16'h4000, 16'h4000, 1'b1, 1'b0);
    step(16'h4040, 16'h4040, 1'b1, 1'b0);
    step(16'h4080, 16'h4080, 1'b1, 1'b1);
    check("mid_rst_sum", 32'(sum), 32'd0);
    step(16'h0, 16'h0, 1'b0, 1'b0);
    step(16'h0, 16'h0, 1'b0, 1'b0);
    check("mid_rst_pulses", 32'(pulses), 32'd1);

    for (int i = 0; i < 400; i++) begin
      step(gen_operand(), gen_operand(), ($urandom_range(0, 3) != 0),
           ($urandom_range(0, 49) == 0));
    end
    step(16'h0, 16'h0, 1'b0, 1'b0);
    step(16'h0, 16'h0, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
